// File: rtl/column_multisrc_l1route.sv
// column_multisrc_l1route: two-stage per-channel cyclic lane rotator with valid/ready flow control
module column_multisrc_l1route #(
    parameter int QUAN_SIZE        = 4,
    parameter int STRIDE_UNIT_SIZE = 51,
    parameter int STRIDE_WIDTH     = 5,
    parameter int SHIFT_W          = $clog2(STRIDE_UNIT_SIZE)
) (
    input  logic                                           sys_clk,
    input  logic                                           rst,
    input  logic                                           in_valid_i,
    output logic                                           in_ready_o,
    input  logic [STRIDE_WIDTH*QUAN_SIZE*STRIDE_UNIT_SIZE-1:0] msg_i,
    input  logic [STRIDE_WIDTH*SHIFT_W-1:0]                shift_i,
    input  logic [STRIDE_WIDTH-1:0]                        dir_i,
    input  logic [STRIDE_WIDTH-1:0]                        chan_en_i,
    output logic                                           out_valid_o,
    input  logic                                           out_ready_i,
    output logic [STRIDE_WIDTH*QUAN_SIZE*STRIDE_UNIT_SIZE-1:0] msg_o,
    output logic                                           shift_err_o
);
    localparam int Z = STRIDE_UNIT_SIZE;
    localparam int Q = QUAN_SIZE;
    localparam int W = STRIDE_WIDTH * Q * Z;

    logic                            v1, v2, en1, en2;
    logic [W-1:0]                    m1, rot;
    logic [STRIDE_WIDTH*SHIFT_W-1:0] s_red, s1;
    logic [STRIDE_WIDTH-1:0]         bad, d1, e1;

    assign en2         = ~v2 | out_ready_i;
    assign en1         = ~v1 | en2;
    assign in_ready_o  = en1;
    assign out_valid_o = v2;

    for (genvar c = 0; c < STRIDE_WIDTH; c++) begin : g_chan
        logic [SHIFT_W-1:0] s, sr;
        assign s      = shift_i[c*SHIFT_W +: SHIFT_W];
        assign bad[c] = s >= SHIFT_W'(Z);
        assign s_red[c*SHIFT_W +: SHIFT_W] = bad[c] ? s - SHIFT_W'(Z) : s;
        assign sr     = s1[c*SHIFT_W +: SHIFT_W];
        // Rotation by shifting a doubled lane vector; s' < Z keeps the window inside it.
        for (genvar b = 0; b < Q; b++) begin : g_plane
            logic [2*Z-1:0] dbl;
            logic [Z-1:0]   dn, up;
            assign dbl = {2{m1[(c*Q+b)*Z +: Z]}};
            assign dn  = Z'(dbl >> sr);
            assign up  = Z'((dbl << sr) >> Z);
            assign rot[(c*Q+b)*Z +: Z] = !e1[c] ? '0 : d1[c] ? up : dn;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            msg_o       <= '0;
            shift_err_o <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid_i;
            if (en2) begin
                v2    <= v1;
                msg_o <= rot;
            end
            if (in_valid_i && en1 && |bad) shift_err_o <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (en1) begin
            m1 <= msg_i;
            s1 <= s_red;
            d1 <= dir_i;
            e1 <= chan_en_i;
        end
    end
endmodule

// File: tb/tb_column_multisrc_l1route.sv
// tb_column_multisrc_l1route: scoreboard bench for the lane rotator
module tb_column_multisrc_l1route;
    localparam int Q  = 4;
    localparam int Z  = 51;
    localparam int C  = 5;
    localparam int SW = 6;
    localparam int W  = C * Q * Z;

    logic          clk, rst, in_valid, in_ready, out_valid, out_ready, shift_err;
    logic [W-1:0]  msg, dout;
    logic [C*SW-1:0] shift;
    logic [C-1:0]  dir, chan_en;

    int checks = 0, errors = 0, out_count = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] prev_msg;
    logic         prev_stall = 1'b0;

    column_multisrc_l1route #(.QUAN_SIZE(Q), .STRIDE_UNIT_SIZE(Z), .STRIDE_WIDTH(C), .SHIFT_W(SW)) dut (
        .sys_clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .msg_i(msg), .shift_i(shift), .dir_i(dir), .chan_en_i(chan_en),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .msg_o(dout), .shift_err_o(shift_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] m, input logic [C*SW-1:0] s,
                                           input logic [C-1:0] d, input logic [C-1:0] e);
        logic [W-1:0] r;
        int sh, src;
        r = '0;
        for (int c = 0; c < C; c++) begin
            sh = int'(s[c*SW +: SW]);
            if (sh >= Z) sh -= Z;
            for (int b = 0; b < Q; b++)
                for (int l = 0; l < Z; l++) begin
                    src = d[c] ? (l - sh + Z) % Z : (l + sh) % Z;
                    if (e[c]) r[(c*Q+b)*Z+l] = m[(c*Q+b)*Z+src];
                end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_msg();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(1, 0));
        return r;
    endfunction

    function automatic logic [C*SW-1:0] rnd_shift();
        logic [C*SW-1:0] r;
        for (int c = 0; c < C; c++) r[c*SW +: SW] = SW'($urandom_range(Z-1, 0));
        return r;
    endfunction

    // Scoreboard: expected beats pushed on input transfer, popped on output transfer.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || dout !== prev_msg) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b got[63:0]=%h held[63:0]=%h", out_valid, dout[63:0], prev_msg[63:0]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                out_count++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_extra: unexpected beat got[63:0]=%h", dout[63:0]);
                end else begin
                    if (dout !== q[0]) begin
                        errors++;
                        $display("FAIL scoreboard_data: got[63:0]=%h expected[63:0]=%h", dout[63:0], q[0][63:0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(msg, shift, dir, chan_en));
            prev_stall <= out_valid && !out_ready;
            prev_msg   <= dout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] m, input logic [C*SW-1:0] s, input logic [C-1:0] d, input logic [C-1:0] e);
        bit ok = 0;
        msg = m; shift = s; dir = d; chan_en = e; in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL out_timeout: out_valid stayed 0 expected 1");
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || shift_err !== 1'b0 || dout !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b err=%b msg_nonzero=%b expected 0 0 0", out_valid, shift_err, |dout);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_rotate(input logic up, input int lane);
        logic [W-1:0] m;
        logic [C*SW-1:0] s;
        logic [C-1:0] d;
        logic [Z-1:0] exp_l;
        m = rnd_msg();
        s = rnd_shift();
        d = C'($urandom);
        for (int b = 0; b < Q; b++) m[b*Z +: Z] = '0;
        for (int b = 0; b < Q; b++) m[b*Z] = 1'b1;
        s[SW-1:0] = SW'(3);
        d[0] = up;
        exp_l = '0;
        exp_l[lane] = 1'b1;
        out_ready = 1'b1;
        send(m, s, d, '1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b expected 0 one cycle after accept", out_valid);
        end
        @(negedge clk);
        for (int b = 0; b < Q; b++) begin
            checks++;
            if (out_valid !== 1'b1 || dout[b*Z +: Z] !== exp_l) begin
                errors++;
                $display("FAIL rotate_dir%0d_plane%0d: valid=%b got=%h expected=%h", up, b, out_valid, dout[b*Z +: Z], exp_l);
            end
        end
        tick();
    endtask

    task automatic test_shift_zero();
        logic [W-1:0] m;
        for (int r = 0; r < 2; r++) begin
            m = rnd_msg();
            send(m, '0, r[0] ? '1 : '0, '1);
            wait_out();
            checks++;
            if (dout !== m) begin
                errors++;
                $display("FAIL shift_zero_dir%0d: got[63:0]=%h expected[63:0]=%h", r, dout[63:0], m[63:0]);
            end
            tick();
        end
    endtask

    task automatic test_shift_err();
        logic [W-1:0] m, e;
        logic [C*SW-1:0] s, s4;
        m = rnd_msg();
        s = '0;
        s[2*SW +: SW] = SW'(55);
        s4 = '0;
        s4[2*SW +: SW] = SW'(4);
        e = model(m, s4, 5'b00100, '1);
        @(negedge clk);
        checks++;
        if (shift_err !== 1'b0) begin
            errors++;
            $display("FAIL err_initial: shift_err=%b expected 0", shift_err);
        end
        tick();
        out_ready = 1'b1;
        send(m, s, 5'b00100, '1);
        @(negedge clk);
        checks++;
        if (shift_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: shift_err=%b expected 1", shift_err);
        end
        wait_out();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL shift55_as_4: got[63:0]=%h expected[63:0]=%h", dout[63:0], e[63:0]);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            send(rnd_msg(), rnd_shift(), C'($urandom), '1);
            @(negedge clk);
            checks++;
            if (shift_err !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky beat %0d: shift_err=%b expected 1", i, shift_err);
            end
            tick();
        end
        repeat (4) tick();
        pulse_rst();
        @(negedge clk);
        checks++;
        if (shift_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: shift_err=%b expected 0", shift_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int base;
        base = out_count;
        fork
            for (int i = 0; i < 10; i++) send(rnd_msg(), rnd_shift(), C'($urandom), '1);
            for (int k = 0; k < 60; k++) begin
                out_ready = (k % 4 == 0) || (k % 4 == 3);
                tick();
            end
        join
        out_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (out_count - base !== 10 || q.size() !== 0) begin
            errors++;
            $display("FAIL back_to_back: beats out=%0d pending=%0d expected 10 0", out_count - base, q.size());
        end
    endtask

    task automatic test_stall_fill();
        out_ready = 1'b0;
        msg = rnd_msg(); shift = rnd_shift(); dir = C'($urandom); chan_en = '1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== (k < 2)) begin
                errors++;
                $display("FAIL stall_fill cycle %0d: in_ready=%b expected %b", k, in_ready, k < 2);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL stall_drain: pending=%0d expected 0", q.size());
        end
    endtask

    task automatic test_chan_en();
        out_ready = 1'b1;
        send('1, rnd_shift(), C'($urandom), 5'b11011);
        wait_out();
        for (int c = 0; c < C; c++) begin
            checks++;
            if (dout[c*Q*Z +: Q*Z] !== (c == 2 ? {Q*Z{1'b0}} : {Q*Z{1'b1}})) begin
                errors++;
                $display("FAIL chan_en ch%0d: got[31:0]=%h expected all %0d", c, dout[c*Q*Z +: 32], c != 2);
            end
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        logic [C*SW-1:0] s;
        s = '0;
        s[SW-1:0] = SW'(55);
        out_ready = 1'b0;
        send(rnd_msg(), s, '0, '1);
        send(rnd_msg(), rnd_shift(), '0, '1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || shift_err !== 1'b1) begin
            errors++;
            $display("FAIL inflight_pre: valid=%b err=%b expected 1 1", out_valid, shift_err);
        end
        tick();
        pulse_rst();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || shift_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL inflight_reset: valid=%b err=%b ready=%b expected 0 0 1", out_valid, shift_err, in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat cycle %0d: out_valid=%b expected 0", k, out_valid);
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        msg = '0; shift = '0; dir = '0; chan_en = '1;
        test_reset();
        test_rotate(1'b0, 48);
        test_rotate(1'b1, 3);
        test_shift_zero();
        test_shift_err();
        test_back_to_back();
        test_stall_fill();
        test_chan_en();
        test_reset_inflight();
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL final_drain: pending=%0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
